// File: rtl/range_burst_driver.sv
// range_burst_driver: emits a burst of incrementing or LFSR samples framed by
// go/finish, tracks the burst's own min/max, then compares the range value
// returned by the downstream range finder and reports pass/fail.
module range_burst_driver #(
    parameter int unsigned      WIDTH    = 12,
    parameter logic [WIDTH-1:0] TAPS     = 12'hE08,
    parameter int unsigned      RESP_LAT = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] seed,
    input  logic [7:0]       length,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    input  logic [WIDTH-1:0] range_in,
    output logic             busy,
    output logic [WIDTH-1:0] expected_range,
    output logic             done,
    output logic             pass
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_FIN  = 3'd2,
        S_WAIT = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               go_q, go_d;
    logic               finish_q, finish_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   exp_q, exp_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   min_q, min_d;
    logic [WIDTH-1:0]   max_q, max_d;

    logic [WIDTH-1:0]   first_c;
    logic [WIDTH-1:0]   next_c;

    // Galois-free Fibonacci step: shift left, parity of tapped bits into bit 0
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] cur);
        return {cur[WIDTH-2:0], ^(cur & TAPS)};
    endfunction

    // First sample (zero LFSR seed would lock up, so it becomes 1) and successor
    always_comb begin
        first_c = seed;
        if (!mode && (seed == '0)) begin
            first_c = WIDTH'(1);
        end
        next_c = mode_q ? (data_q + WIDTH'(1)) : lfsr_next(data_q);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        go_d     = 1'b0;
        finish_d = 1'b0;
        busy_d   = busy_q;
        exp_d    = exp_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        min_d    = min_q;
        max_d    = max_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && (length != '0)) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    data_d  = first_c;
                    go_d    = 1'b1;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    exp_d   = '0;
                    cnt_d   = CNT_W'(length - 8'd1);
                    min_d   = first_c;
                    max_d   = first_c;
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    data_d = next_c;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (next_c < min_q) min_d = next_c;
                    if (next_c > max_q) max_d = next_c;
                end else begin
                    state_d  = S_FIN;
                    finish_d = 1'b1;
                    exp_d    = max_q - min_q;
                end
            end
            S_FIN: begin
                state_d = S_WAIT;
                cnt_d   = CNT_W'(RESP_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_CHK;
                    done_d  = 1'b1;
                    pass_d  = (range_in == exp_q);
                end
            end
            S_CHK: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any burst immediately
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            go_q     <= 1'b0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
            exp_q    <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            min_q    <= '0;
            max_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            go_q     <= go_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
            exp_q    <= exp_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            min_q    <= min_d;
            max_q    <= max_d;
        end
    end

    assign data_out       = data_q;
    assign go             = go_q;
    assign finish         = finish_q;
    assign busy           = busy_q;
    assign expected_range = exp_q;
    assign done           = done_q;
    assign pass           = pass_q;

endmodule

// File: tb/tb_range_burst_driver.sv
// Scoreboard bench for range_burst_driver: stimulus pushes hand-computed
// samples and results; a negedge monitor pops and compares them.
module tb_range_burst_driver;

    localparam int unsigned WIDTH    = 12;
    localparam int unsigned RESP_LAT = 2;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] seed = '0;
    logic [7:0]       length = '0;
    logic [WIDTH-1:0] range_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             go;
    logic             finish;
    logic             busy;
    logic [WIDTH-1:0] expected_range;
    logic             done;
    logic             pass;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             g;
    } samp_t;

    typedef struct {
        logic [WIDTH-1:0] rng;
        logic             p;
        int unsigned      done_cyc;
    } res_t;

    samp_t sq[$];
    res_t  rq[$];

    int unsigned      errors = 0;
    int unsigned      checks = 0;
    int unsigned      cyc = 0;
    bit               in_burst = 1'b0;
    logic [WIDTH-1:0] last_d = '0;

    range_burst_driver #(
        .WIDTH   (WIDTH),
        .TAPS    (12'hE08),
        .RESP_LAT(RESP_LAT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .mode          (mode),
        .seed          (seed),
        .length        (length),
        .data_out      (data_out),
        .go            (go),
        .finish        (finish),
        .range_in      (range_in),
        .busy          (busy),
        .expected_range(expected_range),
        .done          (done),
        .pass          (pass)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_s(input logic [WIDTH-1:0] d, input logic g);
        samp_t s;
        s.d = d;
        s.g = g;
        sq.push_back(s);
    endtask

    // Drive one start cycle and queue the expected check result
    task automatic issue(input logic m, input logic [WIDTH-1:0] s, input logic [7:0] l,
                         input logic [WIDTH-1:0] rin, input logic [WIDTH-1:0] rng,
                         input logic p);
        res_t r;
        mode     = m;
        seed     = s;
        length   = l;
        range_in = rin;
        start    = 1'b1;
        r.rng      = rng;
        r.p        = p;
        r.done_cyc = cyc + int'(l) + RESP_LAT + 2;
        rq.push_back(r);
        @(negedge clock);
        start = 1'b0;
        chk("busy_first_run", 32'(busy), 32'd1);
        chk("pass_cleared", 32'(pass), 32'd0);
    endtask

    // Bounded wait; returns on the negedge where done is seen
    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < 100);
        chk("done_seen", 32'(done), 32'd1);
    endtask

    // Monitor: compare every emitted sample, finish marker and check result
    always @(negedge clock) begin
        if (!reset_n) begin
            in_burst = 1'b0;
        end else begin
            if (go) in_burst = 1'b1;
            if (in_burst && !finish) begin
                if (sq.size() == 0) begin
                    chk("extra_sample", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    samp_t s;
                    s = sq.pop_front();
                    chk("sample", 32'(data_out), 32'(s.d));
                    chk("go_flag", 32'(go), 32'(s.g));
                    chk("busy_run", 32'(busy), 32'd1);
                    last_d = s.d;
                end
            end
            if (finish) begin
                chk("finish_in_burst", 32'(in_burst), 32'd1);
                in_burst = 1'b0;
                chk("fin_hold", 32'(data_out), 32'(last_d));
                chk("samples_left", 32'(sq.size()), 32'd0);
                if (rq.size() != 0) chk("fin_range", 32'(expected_range), 32'(rq[0].rng));
            end
            if (done) begin
                if (rq.size() == 0) begin
                    chk("extra_done", 32'd1, 32'd0);
                end else begin
                    res_t r;
                    r = rq.pop_front();
                    chk("exp_range", 32'(expected_range), 32'(r.rng));
                    chk("pass", 32'(pass), 32'(r.p));
                    chk("done_latency", cyc, r.done_cyc);
                    chk("busy_chk", 32'(busy), 32'd1);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_go", 32'(go), 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_range", 32'(expected_range), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Incrementing, seed 100, length 5
        push_s(12'd100, 1'b1); push_s(12'd101, 1'b0); push_s(12'd102, 1'b0);
        push_s(12'd103, 1'b0); push_s(12'd104, 1'b0);
        issue(1'b1, 12'd100, 8'd5, 12'd4, 12'd4, 1'b1);
        wait_done();
        @(negedge clock);

        // length 0 start ignored; pass and expected_range hold
        mode = 1'b1; seed = 12'd999; length = 8'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("len0_busy", 32'(busy), 32'd0);
            chk("len0_go", 32'(go), 32'd0);
            chk("len0_pass_hold", 32'(pass), 32'd1);
            chk("len0_range_hold", 32'(expected_range), 32'd4);
            @(negedge clock);
        end

        // Incrementing wrap
        push_s(12'hFFE, 1'b1); push_s(12'hFFF, 1'b0); push_s(12'h000, 1'b0); push_s(12'h001, 1'b0);
        issue(1'b1, 12'hFFE, 8'd4, 12'hFFF, 12'hFFF, 1'b1);
        wait_done();
        @(negedge clock);

        // Mismatch
        push_s(12'd10, 1'b1); push_s(12'd11, 1'b0); push_s(12'd12, 1'b0);
        issue(1'b1, 12'd10, 8'd3, 12'd5, 12'd2, 1'b0);
        wait_done();
        @(negedge clock);

        // LFSR, zero seed replaced by 1
        push_s(12'h001, 1'b1); push_s(12'h002, 1'b0); push_s(12'h004, 1'b0);
        issue(1'b0, 12'h000, 8'd3, 12'd3, 12'd3, 1'b1);
        wait_done();
        @(negedge clock);

        // LFSR with feedback: 801 -> 003 -> 006
        push_s(12'h801, 1'b1); push_s(12'h003, 1'b0); push_s(12'h006, 1'b0);
        issue(1'b0, 12'h801, 8'd3, 12'h7FE, 12'h7FE, 1'b1);
        wait_done();
        @(negedge clock);

        // length 1, then start held through CHK into the first IDLE cycle
        push_s(12'h123, 1'b1);
        issue(1'b1, 12'h123, 8'd1, 12'd0, 12'd0, 1'b1);
        wait_done();
        mode = 1'b1; seed = 12'd300; length = 8'd2; start = 1'b1;
        @(negedge clock);
        push_s(12'd300, 1'b1); push_s(12'd301, 1'b0);
        issue(1'b1, 12'd300, 8'd2, 12'd1, 12'd1, 1'b1);
        wait_done();
        @(negedge clock);

        // start during RUN ignored
        push_s(12'd200, 1'b1); push_s(12'd201, 1'b0); push_s(12'd202, 1'b0); push_s(12'd203, 1'b0);
        issue(1'b1, 12'd200, 8'd4, 12'd3, 12'd3, 1'b1);
        seed = 12'd700; length = 8'd2; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done();
        @(negedge clock);

        // Reset on the 3rd RUN cycle
        push_s(12'd100, 1'b1); push_s(12'd101, 1'b0); push_s(12'd102, 1'b0);
        push_s(12'd103, 1'b0); push_s(12'd104, 1'b0);
        issue(1'b1, 12'd100, 8'd5, 12'd4, 12'd4, 1'b1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("abort_data", 32'(data_out), 32'd0);
        chk("abort_go", 32'(go), 32'd0);
        chk("abort_finish", 32'(finish), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_range", 32'(expected_range), 32'd0);
        sq.delete();
        rq.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_idle_busy", 32'(busy), 32'd0);
            chk("post_rst_idle_go", 32'(go), 32'd0);
        end

        // Fresh burst after reset
        push_s(12'd50, 1'b1); push_s(12'd51, 1'b0);
        issue(1'b1, 12'd50, 8'd2, 12'd1, 12'd1, 1'b1);
        wait_done();
        repeat (3) @(negedge clock);

        chk("sq_empty", 32'(sq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/range_burst_driver.md
Name: range_burst_driver

Overview:
- Stimulus/producer side of the range-finder streaming interface (data_in / go / finish / range).
- On a start command, emits a burst of WIDTH-bit samples with go on the first sample and finish after the last sample. Samples are either an incrementing count or an LFSR sequence.
- Tracks the burst's own min/max as it goes, then samples the range value returned by the downstream range finder and reports pass/fail.
- Used for on-chip self-test of the range finder and as the bench-side driver.

Parameters:
- WIDTH, 12, sample and range width.
- TAPS, 12'hE08, LFSR feedback mask (bit i set = cur[i] feeds XOR).
- RESP_LAT, 2, clock cycles between the finish cycle and sampling range_in (1..15).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  one clock; reset is asynchronous and active-low.
- start  input  1  begin a burst (accepted only in IDLE).
- mode  input  1  0 = LFSR samples, 1 = incrementing samples; latched at start.
- seed  input  WIDTH  first sample value; latched at start.
- length  input  8  number of samples in burst; latched at start.
- data_out  output  WIDTH  sample to range finder data_in.
- go  output  1  high only with the first sample.
- finish  output  1  one-cycle end-of-burst marker.
- range_in  input  WIDTH  range result returned by range finder.
- busy  output  1  high in any state other than IDLE.
- expected_range  output  WIDTH  max-min of emitted samples.
- done  output  1  one-cycle pulse when the check completes.
- pass  output  1  result of the last check; valid from the done cycle until the next accepted start.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; data_out, go, finish, busy, done, pass, expected_range, internal min/max/counters all 0. Asserting reset_n low mid-burst aborts immediately. After release, the block stays in IDLE until a new start.
- States: IDLE -> RUN -> FIN -> WAIT -> CHK -> IDLE.
- IDLE: start=1 with length!=0 latches mode/seed/length and clears pass. Next cycle is RUN. start with length==0 is ignored and nothing changes. start outside IDLE is ignored.
- RUN: lasts exactly length cycles, one sample per cycle.
  - Cycle 1: data_out=first sample, go=1. go=0 on all other RUN cycles.
  - Incrementing mode: sample k = seed+k mod 2^WIDTH (wraps FFF->000).
  - LFSR mode: next = {cur[WIDTH-2:0], ^(cur & TAPS)}. A seed of 0 is replaced by 1 before use.
  - Running min/max update on every emitted sample and are initialised by the first sample.
- FIN: exactly 1 cycle; finish=1, data_out holds the last sample, expected_range = max-min (unsigned, never negative).
- WAIT: exactly RESP_LAT cycles; data_out holds.
- CHK: 1 cycle. Sample range_in; done=1; pass=(range_in==expected_range). Next cycle is IDLE.
- Total latency: start accept -> done = length + RESP_LAT + 2 cycles.
- expected_range holds from FIN until the next accepted start, then clears to 0.
- busy=1 from the first RUN cycle through CHK inclusive.
- length=1: go=1 with the single sample; the FIN cycle follows immediately; expected_range=0.
- start asserted in the same cycle as done (CHK) is ignored. A start on the first IDLE cycle after CHK is accepted.

Test Plan:
- Incrementing, seed=100, length=5, range_in=4 at CHK -> data_out 100,101,102,103,104. go only on the 100 cycle. finish on the next cycle. expected_range=4, done pulse, pass=1, done exactly 9 cycles after start.
- Incrementing wrap, seed=0xFFE, length=4, range_in=0xFFF -> samples FFE,FFF,000,001. expected_range=0xFFF, pass=1.
- Mismatch: incrementing seed=10, length=3, range_in=5 -> expected_range=2, done=1, pass=0.
- LFSR, seed=0, length=3 -> first sample 0x001, then 0x002, 0x004 (TAPS=E08, feedback bit 0). expected_range=3.
- length=0 start, then start during RUN -> both ignored: no go, busy unchanged, burst sample count unchanged.
- reset_n low on the 3rd RUN cycle -> all outputs 0 within the same cycle. After release, stays IDLE. A fresh start runs a normal burst.
